// File: rtl/wb_mailbox_slave_if.sv
// Pipelined Wishbone bus bundle shared by the mailbox responder and its
// initiator. The master modport drives the request side and the slave
// modport drives the response side.
interface wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m;
    logic [DATA_WIDTH-1:0]   dat_s;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic                    stall;
    logic                    err;

    modport master (
        output adr, dat_m, we, sel, cyc, stb,
        input  dat_s, ack, stall, err
    );

    modport slave (
        input  adr, dat_m, we, sel, cyc, stb,
        output dat_s, ack, stall, err
    );
endinterface

// File: rtl/wb_mailbox_slave.sv
// Wishbone mailbox: a word FIFO behind four word-offset registers
// (DATA push/pop, STATUS, IRQ_EN, CLEAR) with a level interrupt.
// Every accepted request is answered one cycle later; stall is never used.
// Build option WB_MAILBOX_ERR_EN: when defined, overflow pushes and
// underflow pops answer with err instead of ack; otherwise err is tied 0.
module wb_mailbox_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wbs,
    output logic irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    // FIFO storage holds payload only and is deliberately left unreset
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  irq_en_q, irq_en_d;
    logic                  irq_q;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic       accept;
    logic       is_push, is_pop, is_clr, is_ien;
    logic       empty, full, overflow, underflow;
    logic       resp_err;
    logic       live;
    logic       ack_out;
    logic [8:0] level9;
    logic       unused_bits;

    // Upper address bits are pre-decoded by the interconnect; sel only
    // matters for the IRQ_EN enable bit.
    assign unused_bits = ^{wbs.adr[ADDR_WIDTH-1:2], wbs.sel[DATA_WIDTH/8-1:1]};

    assign accept    = wbs.cyc & wbs.stb & ~rst;
    assign is_push   = accept &  wbs.we & (wbs.adr[1:0] == REG_DATA);
    assign is_pop    = accept & ~wbs.we & (wbs.adr[1:0] == REG_DATA);
    assign is_clr    = accept &  wbs.we & (wbs.adr[1:0] == REG_CLEAR);
    assign is_ien    = accept &  wbs.we & (wbs.adr[1:0] == REG_IRQ_EN);

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign overflow  = is_push & full;
    assign underflow = is_pop & empty;
    assign level9    = 9'(level_q);

    // Next-state for FIFO bookkeeping and the read-data mux
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        irq_en_d = irq_en_q;
        dat_d    = '0;

        // A flush wins; only one request can be accepted per cycle anyway
        if (is_clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else if (is_push && !overflow) begin
            wptr_d  = wptr_q + 1'b1;
            level_d = level_q + 1'b1;
        end else if (is_pop && !underflow) begin
            rptr_d  = rptr_q + 1'b1;
            level_d = level_q - 1'b1;
        end

        if (is_ien && wbs.sel[0]) begin
            irq_en_d = wbs.dat_m[0];
        end

        if (accept && !wbs.we) begin
            case (wbs.adr[1:0])
                REG_DATA:   dat_d = underflow ? '0 : mem[rptr_q];
                REG_STATUS: dat_d = DATA_WIDTH'({level9, 6'b0, full, empty});
                REG_IRQ_EN: dat_d = DATA_WIDTH'(irq_en_q);
                default:    dat_d = '0;
            endcase
        end
    end

    assign ack_d = accept & ~resp_err;

    // Control state: pointers, level, enable, interrupt and response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & ~empty;
            ack_q    <= ack_d;
        end
    end

    // Data path: response word register and FIFO writes
    always_ff @(posedge clk) begin
        dat_q <= dat_d;
        if (is_push && !overflow) begin
            mem[wptr_q] <= wbs.dat_m;
        end
    end

    // A response is only presented while the cycle is still open and the
    // block is not being reset; the side effect has already happened.
    assign live = wbs.cyc & ~rst;

`ifdef WB_MAILBOX_ERR_EN
    logic err_q;

    assign resp_err = overflow | underflow;

    // Error response flag for overflow/underflow requests
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & resp_err;
        end
    end

    assign wbs.err = err_q & live;
`else
    assign resp_err = 1'b0;
    assign wbs.err  = 1'b0;
`endif

    assign ack_out   = ack_q & live;
    assign wbs.ack   = ack_out;
    assign wbs.dat_s = ack_out ? dat_q : '0;
    assign wbs.stall = 1'b0;
    assign irq       = irq_q;
endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Bench for wb_mailbox_slave: a software FIFO model predicts every response,
// entries are queued when a request is accepted and checked by a monitor in
// the cycle the response is due.
module tb_wb_mailbox_slave;
    localparam int DEPTH = 16;
`ifdef WB_MAILBOX_ERR_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic clk;
    logic rst;
    logic irq;

    wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbs ();

    wb_mailbox_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wbs(wbs),
        .irq(irq)
    );

    sb_t         sb [$];
    logic [31:0] mdl [$];
    bit          mdl_irq_en;
    int          total;
    int          bad;
    int          cyc_cnt;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        int n;
        n = mdl.size();
        s = '0;
        s[0] = (n == 0);
        s[1] = (n == DEPTH);
        s[16:8] = 9'(n);
        return s;
    endfunction

    // mode 0: normal, 1: drop cyc after acceptance, 2: assert rst after acceptance
    task automatic req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int mode);
        sb_t e;
        e.err = 1'b0;
        e.chk = 1'b0;
        e.data = '0;
        e.cyc = 0;
        case (adr[1:0])
            2'd0: begin
                if (we) begin
                    if (mdl.size() == DEPTH) e.err = ERR_EXP;
                    else mdl.push_back(dat);
                end else begin
                    e.chk = 1'b1;
                    if (mdl.size() == 0) e.err = ERR_EXP;
                    else e.data = mdl.pop_front();
                end
            end
            2'd1: begin
                if (!we) begin
                    e.chk = 1'b1;
                    e.data = status_exp();
                end
            end
            2'd2: begin
                if (we) begin
                    if (sel[0]) mdl_irq_en = dat[0];
                end else begin
                    e.chk = 1'b1;
                    e.data = {31'b0, mdl_irq_en};
                end
            end
            default: begin
                if (we) mdl.delete();
                else e.chk = 1'b1;
            end
        endcase
        wbs.cyc = 1'b1;
        wbs.stb = 1'b1;
        wbs.we = we;
        wbs.adr = adr;
        wbs.dat_m = dat;
        wbs.sel = sel;
        @(posedge clk);
        #1;
        e.cyc = cyc_cnt;
        if (mode == 0) begin
            sb.push_back(e);
        end else if (mode == 1) begin
            wbs.cyc = 1'b0;
            wbs.stb = 1'b0;
        end else begin
            wbs.stb = 1'b0;
            rst = 1'b1;
        end
    endtask

    task automatic idle();
        wbs.stb = 1'b0;
        @(posedge clk);
        #1;
        wbs.cyc = 1'b0;
    endtask

    // Response monitor: checks kind, data and exact one-cycle latency
    always @(negedge clk) begin
        sb_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
                e = sb.pop_front();
                total++;
                if (wbs.ack !== !e.err || wbs.err !== e.err) begin
                    bad++;
                    $display("FAIL resp_kind cyc=%0d ack=%b err=%b expected ack=%b err=%b",
                             cyc_cnt, wbs.ack, wbs.err, !e.err, e.err);
                end
                if (e.chk) begin
                    total++;
                    if (wbs.dat_s !== e.data) begin
                        bad++;
                        $display("FAIL resp_data cyc=%0d got=%h expected=%h",
                                 cyc_cnt, wbs.dat_s, e.data);
                    end
                end
            end else begin
                total++;
                if (wbs.ack !== 1'b0 || wbs.err !== 1'b0) begin
                    bad++;
                    $display("FAIL spurious_resp cyc=%0d ack=%b err=%b expected 0/0",
                             cyc_cnt, wbs.ack, wbs.err);
                end
                total++;
                if (wbs.dat_s !== 32'h0) begin
                    bad++;
                    $display("FAIL dat_idle cyc=%0d got=%h expected 0", cyc_cnt, wbs.dat_s);
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        total++;
        if (wbs.ack !== 1'b0 || wbs.err !== 1'b0 || wbs.dat_s !== 32'h0 ||
            wbs.stall !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL %s ack=%b err=%b dat_s=%h stall=%b irq=%b expected all 0",
                     name, wbs.ack, wbs.err, wbs.dat_s, wbs.stall, irq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wbs.cyc = 1'b0;
        wbs.stb = 1'b0;
        wbs.we = 1'b0;
        wbs.adr = '0;
        wbs.dat_m = '0;
        wbs.sel = '0;
        mdl.delete();
        mdl_irq_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_quiet("reset_outputs");
        rst = 1'b0;
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        req(1'b0, 32'h2, 32'h0, 4'hF, 0);
        idle();
    endtask

    task automatic test_regs();
        req(1'b1, 32'h2, 32'h1, 4'b1110, 0);
        req(1'b0, 32'h2, 32'h0, 4'hF, 0);
        req(1'b1, 32'h2, 32'h1, 4'b0001, 0);
        req(1'b0, 32'h2, 32'h0, 4'hF, 0);
        req(1'b1, 32'h2, 32'h0, 4'b0001, 0);
        req(1'b0, 32'h2, 32'h0, 4'hF, 0);
        req(1'b0, 32'h3, 32'h0, 4'hF, 0);
        req(1'b0, 32'hDEAD_BE01, 32'h0, 4'hF, 0);
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            req(1'b1, 32'h0, 32'hA5A5_0000 + 32'(i), 4'h0, 0);
        end
        total++;
        if (wbs.stall !== 1'b0) begin
            bad++;
            $display("FAIL stall got=%b expected 0", wbs.stall);
        end
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        for (int i = 0; i < 3; i++) begin
            req(1'b0, 32'h0, 32'h0, 4'hF, 0);
        end
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            req(1'b1, 32'h0, 32'hB000_0000 + 32'(i), 4'hF, 0);
        end
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        total++;
        if (status_exp() !== 32'h0000_1002) begin
            bad++;
            $display("FAIL model_full got=%h expected=%h", status_exp(), 32'h0000_1002);
        end
        for (int i = 0; i < DEPTH; i++) begin
            req(1'b0, 32'h0, 32'h0, 4'hF, 0);
        end
        idle();
    endtask

    task automatic test_underflow();
        req(1'b0, 32'h0, 32'h0, 4'hF, 0);
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        idle();
    endtask

    task automatic test_irq();
        req(1'b1, 32'h2, 32'h1, 4'h1, 0);
        req(1'b1, 32'h0, 32'h0000_1234, 4'hF, 0);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_early got=%b expected 0", irq);
        end
        idle();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_set got=%b expected 1", irq);
        end
        req(1'b1, 32'h3, 32'h0, 4'hF, 0);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_hold got=%b expected 1", irq);
        end
        idle();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear got=%b expected 0", irq);
        end
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        req(1'b1, 32'h2, 32'h0, 4'h1, 0);
        idle();
    endtask

    task automatic test_cancel();
        req(1'b1, 32'h0, 32'hC0DE_0001, 4'hF, 1);
        @(negedge clk);
        total++;
        if (wbs.ack !== 1'b0 || wbs.err !== 1'b0) begin
            bad++;
            $display("FAIL cancel_resp ack=%b err=%b expected 0/0", wbs.ack, wbs.err);
        end
        @(posedge clk);
        #1;
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        req(1'b0, 32'h0, 32'h0, 4'hF, 0);
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        idle();
    endtask

    task automatic test_reset_pending();
        req(1'b1, 32'h2, 32'h1, 4'h1, 0);
        req(1'b1, 32'h0, 32'hDEAD_0001, 4'hF, 0);
        idle();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_before_rst got=%b expected 1", irq);
        end
        req(1'b0, 32'h0, 32'h0, 4'hF, 2);
        @(negedge clk);
        total++;
        if (wbs.ack !== 1'b0 || wbs.err !== 1'b0) begin
            bad++;
            $display("FAIL rst_pending_resp ack=%b err=%b expected 0/0", wbs.ack, wbs.err);
        end
        @(posedge clk);
        #1;
        check_quiet("rst_mid_outputs");
        rst = 1'b0;
        wbs.cyc = 1'b0;
        mdl.delete();
        mdl_irq_en = 1'b0;
        req(1'b0, 32'h1, 32'h0, 4'hF, 0);
        req(1'b0, 32'h2, 32'h0, 4'hF, 0);
        req(1'b1, 32'h0, 32'hEEEE_0001, 4'hF, 0);
        req(1'b0, 32'h0, 32'h0, 4'hF, 0);
        idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc_cnt = 0;
        mon_en = 1'b0;
        test_reset();
        test_regs();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_irq();
        test_cancel();
        test_reset_pending();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_resp pending=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d expected completion", cyc_cnt);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_mailbox_slave.md
WB_MAILBOX_SLAVE -- requirements
Module: wb_mailbox_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: Wishbone data width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: Wishbone word address width.
REQ-003 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, 2..256.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wbs, wb_if.slave, bundle: pipelined Wishbone responder (adr, dat_m, dat_s, we, sel, cyc, stb, ack, stall, err).
REQ-007 SHALL have port irq, output, 1: level interrupt, non-empty AND IRQ_EN.

Function
REQ-008 SHALL decode registers on adr[1:0] (word offsets) and ignore upper address bits, the mux having done selection.
- 0 DATA: write pushes, read pops.
- 1 STATUS: read-only; bit0 empty, bit1 full, bits[16:8] level.
- 2 IRQ_EN: bit0 R/W.
- 3 CLEAR: a write flushes the FIFO; reads return 0.
REQ-009 SHALL accept a request when cyc&stb; stall is held 0.
REQ-010 SHALL assert ack (or err) exactly one cycle after acceptance, for one cycle, one response per accepted request, in order.
REQ-011 SHALL register dat_s with ack; dat_s SHALL be 0 whenever ack is low.
REQ-012 SHALL honour sel on IRQ_EN writes; sel SHALL be ignored on DATA pushes (full word).
REQ-013 SHALL cancel a pending response if cyc falls in the cycle after acceptance, while still applying the side effect (push, pop, flush) exactly once.
REQ-014 SHALL implement the FIFO with wrapping read/write pointers of log2(DEPTH) bits and a level counter of log2(DEPTH)+1 bits.
REQ-015 SHALL handle a push when full as overflow: data dropped, level unchanged.
REQ-016 SHALL handle a pop when empty as underflow: returns 0, pointers unchanged.
REQ-017 SHALL give CLEAR priority: the FIFO is empty from the next cycle.
REQ-018 SHALL update irq one cycle after the level or IRQ_EN change that affects it.
REQ-019 SHALL sustain back-to-back requests every cycle, with each read observing the effect of all earlier accepted writes.

Reset
REQ-020 SHALL, in the cycle after rst high, hold ack=0, err=0, dat_s=0, stall=0, irq=0, pointers=0, level=0, IRQ_EN=0.
REQ-021 SHALL, on rst asserted mid-transaction, drop the pending response with no ack or err.
REQ-022 SHALL NOT reset the FIFO storage array.

Configuration
REQ-023 SHALL honour macro WB_MAILBOX_ERR_EN.
- Defined: overflow pushes and underflow pops respond with err instead of ack.
- Undefined: they respond with ack and err is tied 0.
- Dropped-data and zero-return behaviour SHALL be identical in both builds.

Verification
REQ-024 SHALL cover: after reset, read STATUS -> ack at +1 cycle, dat_s=0x00000001.
REQ-025 SHALL cover: push 0xA5A5_0001..0xA5A5_0003 back-to-back, then three pops -> data in order, STATUS level=3 then 0.
REQ-026 SHALL cover: push 17 words with DEPTH=16 -> 17th gets err (ERR_EN) or ack (no ERR_EN), STATUS=0x00001002, first pop returns word 1.
REQ-027 SHALL cover: pop when empty -> dat_s=0, err (ERR_EN) or ack (no ERR_EN), level stays 0.
REQ-028 SHALL cover: IRQ_EN=1, then push 0x1234 -> irq high one cycle after push ack; write CLEAR -> irq low, STATUS=0x00000001.
REQ-029 SHALL cover: drop cyc the cycle after a push request, and separately assert rst during a pending pop -> no ack/err, push applied once, state reset per REQ-020.
